reorder_buffer: RTL and testbench

- Circular in-order retirement queue directly downstream of the execution units and upstream of the register file rename/commit port.
- Allocates ROB ids at issue, captures CDB results, and retires one entry per cycle in program order.
- Drives the register-file commit and flush interface: commit_valid/dest/value/RobId and jump_flag.
- Id 0 is reserved to mean "not renamed", so usable ids are 1..ROB_SIZE-1.

---
 rtl/reorder_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates ids at issue, captures CDB results, retires one entry per cycle.
// Optional define ROB_BYPASS_EN forwards a same-cycle CDB broadcast to the operand queries.
module rob_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        set_i,
  input  logic        wb_i,
  input  logic        clr_i,
  input  logic        flush_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  type_i,
  input  logic        pred_i,
  input  logic [31:0] value_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic        alloc_o,
  output logic        ready_o,
  output logic [4:0]  rd_o,
  output logic [1:0]  type_o,
  output logic        pred_o,
  output logic [31:0] value_o,
  output logic        taken_o,
  output logic [31:0] target_o
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_o  <= 1'b0;
      ready_o  <= 1'b0;
      rd_o     <= '0;
      type_o   <= '0;
      pred_o   <= 1'b0;
      value_o  <= '0;
      taken_o  <= 1'b0;
      target_o <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        alloc_o <= 1'b0;
        ready_o <= 1'b0;
      end else if (set_i) begin
        alloc_o <= 1'b1;
        ready_o <= 1'b0;
        rd_o    <= rd_i;
        type_o  <= type_i;
        pred_o  <= pred_i;
      end else if (clr_i) begin
        alloc_o <= 1'b0;
        ready_o <= 1'b0;
      end else if (wb_i && alloc_o) begin
        // results for ids not currently allocated are dropped here
        ready_o  <= 1'b1;
        value_o  <= value_i;
        taken_o  <= taken_i;
        target_o <= target_i;
      end
    end
  end
endmodule

module reorder_buffer #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic [1:0]         issue_type,
  input  logic               issue_pred_taken,
  output logic [ROB_LOG-1:0] issue_RobId,
  output logic               rob_full,
  input  logic               cdb_valid,
  input  logic [ROB_LOG-1:0] cdb_RobId,
  input  logic [31:0]        cdb_value,
  input  logic               cdb_taken,
  input  logic [31:0]        cdb_target,
  input  logic [ROB_LOG-1:0] query_j_id,
  input  logic [ROB_LOG-1:0] query_k_id,
  output logic               query_j_ready,
  output logic               query_k_ready,
  output logic [31:0]        query_j_value,
  output logic [31:0]        query_k_value,
  output logic               commit_valid,
  output logic [4:0]         commit_dest,
  output logic [31:0]        commit_value,
  output logic [ROB_LOG-1:0] commit_RobId,
  output logic               store_commit_valid,
  output logic [ROB_LOG-1:0] store_commit_RobId,
  output logic               jump_flag,
  output logic [31:0]        jump_pc
);
  localparam int ROB_SIZE = 1 << ROB_LOG;
  typedef logic [ROB_LOG-1:0] id_t;
  typedef struct packed { logic ready; logic [31:0] value; } qrsp_t;

  function automatic id_t nxt(input id_t x);
    return (x == id_t'(ROB_SIZE-1)) ? id_t'(1) : x + id_t'(1);
  endfunction

  id_t head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic flush_q, flush_d;
  logic cv_q, cv_d, sv_q, sv_d, jf_q, jf_d;
  logic [4:0]  cdest_q, cdest_d;
  logic [31:0] cval_q, cval_d, jpc_q, jpc_d;
  id_t cid_q, cid_d, sid_q, sid_d;

  logic [ROB_SIZE-1:0]       e_alloc, e_ready, e_pred, e_taken;
  logic [ROB_SIZE-1:0][4:0]  e_rd;
  logic [ROB_SIZE-1:0][1:0]  e_type;
  logic [ROB_SIZE-1:0][31:0] e_value, e_target;

  logic issue_acc, commit, mispred;
  assign rob_full    = (count_q == id_t'(ROB_SIZE-1));
  assign issue_RobId = tail_q;
  assign issue_acc   = issue_valid && !rob_full && !flush_q;
  assign commit      = (count_q != '0) && e_ready[head_q];
  assign mispred     = commit && (e_type[head_q] == 2'd1) && (e_taken[head_q] != e_pred[head_q]);

  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
    rob_entry u_ent (
      .clk(clk), .rst(rst), .en_i(rdy),
      .set_i(issue_acc && (tail_q == id_t'(i))),
      .wb_i(cdb_valid && (cdb_RobId == id_t'(i))),
      .clr_i(commit && (head_q == id_t'(i))),
      .flush_i(mispred),
      .rd_i(issue_rd), .type_i(issue_type), .pred_i(issue_pred_taken),
      .value_i(cdb_value), .taken_i(cdb_taken), .target_i(cdb_target),
      .alloc_o(e_alloc[i]), .ready_o(e_ready[i]), .rd_o(e_rd[i]), .type_o(e_type[i]),
      .pred_o(e_pred[i]), .value_o(e_value[i]), .taken_o(e_taken[i]), .target_o(e_target[i])
    );
  end

  function automatic qrsp_t lookup(input id_t id);
    qrsp_t r;
    r.ready = e_alloc[id] && e_ready[id];
    r.value = (id == '0) ? 32'd0 : e_value[id];
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_RobId == id) && e_alloc[id]) begin
      r.ready = 1'b1;
      r.value = cdb_value;
    end
`endif
    return r;
  endfunction

  always_comb begin
    qrsp_t qj, qk;
    qj = lookup(query_j_id);
    qk = lookup(query_k_id);
    query_j_ready = qj.ready;
    query_j_value = qj.value;
    query_k_ready = qk.ready;
    query_k_value = qk.value;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    flush_d = flush_q;
    cv_d    = 1'b0;
    cdest_d = cdest_q;
    cval_d  = cval_q;
    cid_d   = cid_q;
    sv_d    = 1'b0;
    sid_d   = sid_q;
    jf_d    = 1'b0;
    jpc_d   = jpc_q;
    if (rdy) begin
      flush_d = mispred;
      if (commit) begin
        head_d = nxt(head_q);
        if (e_type[head_q] == 2'd2) begin
          sv_d  = 1'b1;
          sid_d = head_q;
        end else begin
          cv_d    = 1'b1;
          cdest_d = e_rd[head_q];
          cval_d  = e_value[head_q];
          cid_d   = head_q;
        end
      end
      // a mispredict squashes everything younger, including a same-cycle issue
      if (mispred) begin
        jf_d    = 1'b1;
        jpc_d   = e_target[head_q];
        head_d  = id_t'(1);
        tail_d  = id_t'(1);
        count_d = '0;
      end else begin
        if (issue_acc) tail_d = nxt(tail_q);
        count_d = count_q + {{(ROB_LOG-1){1'b0}}, issue_acc} - {{(ROB_LOG-1){1'b0}}, commit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= id_t'(1);
      tail_q  <= id_t'(1);
      count_q <= '0;
      flush_q <= 1'b0;
      cv_q    <= 1'b0;
      cdest_q <= '0;
      cval_q  <= '0;
      cid_q   <= '0;
      sv_q    <= 1'b0;
      sid_q   <= '0;
      jf_q    <= 1'b0;
      jpc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
      cv_q    <= cv_d;
      cdest_q <= cdest_d;
      cval_q  <= cval_d;
      cid_q   <= cid_d;
      sv_q    <= sv_d;
      sid_q   <= sid_d;
      jf_q    <= jf_d;
      jpc_q   <= jpc_d;
    end
  end

  assign commit_valid       = cv_q;
  assign commit_dest        = cdest_q;
  assign commit_value       = cval_q;
  assign commit_RobId       = cid_q;
  assign store_commit_valid = sv_q;
  assign store_commit_RobId = sid_q;
  assign jump_flag          = jf_q;
  assign jump_pc            = jpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for issue/writeback/commit, hand sequences for flush, wrap, freeze, bypass, reset.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_taken;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_type;
  logic [3:0]  issue_RobId;
  logic        rob_full;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_RobId;
  logic [31:0] cdb_value, cdb_target;
  logic [3:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        commit_valid, store_commit_valid, jump_flag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value, jump_pc;
  logic [3:0]  commit_RobId, store_commit_RobId;

  reorder_buffer #(.ROB_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_type(issue_type),
    .issue_pred_taken(issue_pred_taken), .issue_RobId(issue_RobId), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_RobId(commit_RobId), .store_commit_valid(store_commit_valid),
    .store_commit_RobId(store_commit_RobId), .jump_flag(jump_flag), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [4:0] rd; logic [1:0] ty; logic pr;
    logic cv; logic [3:0] cid; logic [31:0] cval; logic tk; logic [31:0] tg;
    logic [3:0] e_id; logic e_full;
    logic e_cv; logic [4:0] e_dest; logic [31:0] e_val; logic [3:0] e_cid;
    logic e_sv; logic [3:0] e_sid; logic e_jf; logic [31:0] e_jpc;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic row(input int iv, rd, ty, pr, cv, cid, cval, tk, tg,
                     eid, efull, ecv, edest, evalue, ecid, esv, esid, ejf, ejpc);
    vec_t v;
    v.iv = 1'(iv); v.rd = 5'(rd); v.ty = 2'(ty); v.pr = 1'(pr);
    v.cv = 1'(cv); v.cid = 4'(cid); v.cval = 32'(cval); v.tk = 1'(tk); v.tg = 32'(tg);
    v.e_id = 4'(eid); v.e_full = 1'(efull);
    v.e_cv = 1'(ecv); v.e_dest = 5'(edest); v.e_val = 32'(evalue); v.e_cid = 4'(ecid);
    v.e_sv = 1'(esv); v.e_sid = 4'(esid); v.e_jf = 1'(ejf); v.e_jpc = 32'(ejpc);
    vq.push_back(v);
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_type = '0; issue_pred_taken = 1'b0;
    cdb_valid = 1'b0; cdb_RobId = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; query_j_id = '0; query_k_id = '0;
    idle();
    //   iv rd ty pr  cv cid cval     tk tg     | id full | cv dest val      cid | sv sid | jf jpc
    row(1, 5, 0, 0,  0, 0, 0,        0, 0,      1, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 1, 'h1234,   0, 0,      2, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      2, 0,  1, 5, 'h1234,   1,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      2, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(1, 1, 0, 0,  0, 0, 0,        0, 0,      2, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(1, 2, 0, 0,  0, 0, 0,        0, 0,      3, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(1, 3, 0, 0,  0, 0, 0,        0, 0,      4, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 4, 'h33,     0, 0,      5, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 3, 'h22,     0, 0,      5, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 2, 'h11,     0, 0,      5, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      5, 0,  1, 1, 'h11,     2,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      5, 0,  1, 2, 'h22,     3,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      5, 0,  1, 3, 'h33,     4,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      5, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(1, 0, 2, 0,  0, 0, 0,        0, 0,      5, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 5, 0,        0, 0,      6, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      6, 0,  0, 0, 0,        0,  1, 5,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      6, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(1, 1, 1, 1,  0, 0, 0,        0, 0,      6, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  1, 6, 'h40,     1, 'h99,   7, 0,  0, 0, 0,        0,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      7, 0,  1, 1, 'h40,     6,  0, 0,  0, 0);
    row(0, 0, 0, 0,  0, 0, 0,        0, 0,      7, 0,  0, 0, 0,        0,  0, 0,  0, 0);

    #12;
    chk("rst_issue_id", 32'(issue_RobId), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_cv", 32'(commit_valid), 32'd0);
    chk("rst_sv", 32'(store_commit_valid), 32'd0);
    chk("rst_jf", 32'(jump_flag), 32'd0);
    chk("rst_qj_rdy", 32'(query_j_ready), 32'd0);
    rst = 1'b1;
    cyc();

    foreach (vq[k]) begin
      issue_valid = vq[k].iv; issue_rd = vq[k].rd; issue_type = vq[k].ty; issue_pred_taken = vq[k].pr;
      cdb_valid = vq[k].cv; cdb_RobId = vq[k].cid; cdb_value = vq[k].cval;
      cdb_taken = vq[k].tk; cdb_target = vq[k].tg;
      @(negedge clk);
      chk($sformatf("v%0d_issue_id", k), 32'(issue_RobId), 32'(vq[k].e_id));
      chk($sformatf("v%0d_full", k), 32'(rob_full), 32'(vq[k].e_full));
      cyc();
      chk($sformatf("v%0d_cv", k), 32'(commit_valid), 32'(vq[k].e_cv));
      chk($sformatf("v%0d_sv", k), 32'(store_commit_valid), 32'(vq[k].e_sv));
      chk($sformatf("v%0d_jf", k), 32'(jump_flag), 32'(vq[k].e_jf));
      if (vq[k].e_cv) begin
        chk($sformatf("v%0d_dest", k), 32'(commit_dest), 32'(vq[k].e_dest));
        chk($sformatf("v%0d_val", k), commit_value, vq[k].e_val);
        chk($sformatf("v%0d_cid", k), 32'(commit_RobId), 32'(vq[k].e_cid));
      end
      if (vq[k].e_sv) chk($sformatf("v%0d_sid", k), 32'(store_commit_RobId), 32'(vq[k].e_sid));
    end
    idle();

    // mispredicted branch at id1 flushes the younger id2 and a same-cycle issue
    rst = 1'b0; #2; rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd1; issue_type = 2'd1; issue_pred_taken = 1'b0;
    cyc();
    issue_rd = 5'd7; issue_type = 2'd0;
    cdb_valid = 1'b1; cdb_RobId = 4'd1; cdb_value = 32'h44; cdb_taken = 1'b1; cdb_target = 32'h80;
    cyc();
    issue_rd = 5'd9; cdb_RobId = 4'd2; cdb_value = 32'h55; cdb_taken = 1'b0; cdb_target = '0;
    cyc();
    chk("br_jf", 32'(jump_flag), 32'd1);
    chk("br_jpc", jump_pc, 32'h80);
    chk("br_cv", 32'(commit_valid), 32'd1);
    chk("br_cid", 32'(commit_RobId), 32'd1);
    chk("br_val", commit_value, 32'h44);
    chk("br_issue_id", 32'(issue_RobId), 32'd1);
    cdb_RobId = 4'd2; cdb_value = 32'h66; query_j_id = 4'd2;
    #1;
    chk("br_young_q", 32'(query_j_ready), 32'd0);
    cyc();
    chk("br_jf_pulse", 32'(jump_flag), 32'd0);
    chk("br_issue_blocked", 32'(issue_RobId), 32'd1);
    chk("br_young_ign", 32'(query_j_ready), 32'd0);
    idle();

    // fill to capacity, check the id sequence and wrap
    for (int i = 0; i < 15; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("fill_id%0d", i), 32'(issue_RobId), 32'(i + 1));
      chk($sformatf("fill_full%0d", i), 32'(rob_full), 32'd0);
      cyc();
    end
    chk("full_set", 32'(rob_full), 32'd1);
    chk("full_wrap_id", 32'(issue_RobId), 32'd1);
    issue_rd = 5'd31;
    cyc();
    chk("full_ign_full", 32'(rob_full), 32'd1);
    chk("full_ign_id", 32'(issue_RobId), 32'd1);
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_RobId = 4'd1; cdb_value = 32'hA1;
    cyc();
    chk("full_cdb_cv", 32'(commit_valid), 32'd0);
    cdb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd30;
    cyc();
    chk("full_cmt_cv", 32'(commit_valid), 32'd1);
    chk("full_cmt_cid", 32'(commit_RobId), 32'd1);
    chk("full_cmt_val", commit_value, 32'hA1);
    chk("full_cmt_nofull", 32'(rob_full), 32'd0);
    chk("full_cmt_id", 32'(issue_RobId), 32'd1);

    // same-cycle query of an id being broadcast
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_RobId = 4'd2; cdb_value = 32'd7; query_j_id = 4'd2; query_k_id = 4'd0;
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_rdy", 32'(query_j_ready), 32'd1);
    chk("byp_val", query_j_value, 32'd7);
`else
    chk("nobyp_rdy", 32'(query_j_ready), 32'd0);
`endif
    chk("q0_rdy", 32'(query_k_ready), 32'd0);
    chk("q0_val", query_k_value, 32'd0);
    cyc();
    cdb_valid = 1'b0; rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd29;
    #1;
    chk("q_reg_rdy", 32'(query_j_ready), 32'd1);
    chk("q_reg_val", query_j_value, 32'd7);

    // freeze: commit condition and issue both pending, nothing may move
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("frz_cv%0d", i), 32'(commit_valid), 32'd0);
      chk($sformatf("frz_id%0d", i), 32'(issue_RobId), 32'd1);
      chk($sformatf("frz_q%0d", i), 32'(query_j_ready), 32'd1);
    end
    rdy = 1'b1; issue_valid = 1'b0;
    cyc();
    chk("thaw_cv", 32'(commit_valid), 32'd1);
    chk("thaw_cid", 32'(commit_RobId), 32'd2);
    chk("thaw_dest", 32'(commit_dest), 32'd2);
    chk("thaw_val", commit_value, 32'd7);

    // asynchronous reset mid-cycle clears everything at once
    #2; rst = 1'b0; #1;
    chk("ar_cv", 32'(commit_valid), 32'd0);
    chk("ar_dest", 32'(commit_dest), 32'd0);
    chk("ar_val", commit_value, 32'd0);
    chk("ar_cid", 32'(commit_RobId), 32'd0);
    chk("ar_sv", 32'(store_commit_valid), 32'd0);
    chk("ar_jf", 32'(jump_flag), 32'd0);
    chk("ar_jpc", jump_pc, 32'd0);
    chk("ar_full", 32'(rob_full), 32'd0);
    chk("ar_issue_id", 32'(issue_RobId), 32'd1);
    chk("ar_q", 32'(query_j_ready), 32'd0);
    rst = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
